axi_burst_mem_slave: RTL and testbench
======================================

Name: axi_burst_mem_slave

Overview:
- AXI4 burst responder (slave) that terminates the vector core's AXI master port: v_m_axi_* outputs land on its inputs, and its outputs land on v_m_axi_* inputs.
- Backs an on-chip word-addressed memory with byte write enables.
- Serves INCR bursts of full-width beats on independent read and write channels.
- Used as the data memory behind the vector subsystem in simulation and FPGA bring-up.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, byte address width.
- C_M_AXI_DATA_WIDTH, 32, beat width in bits; power of two, at least 32.
- MEM_DEPTH, 4096, memory depth in words of C_M_AXI_DATA_WIDTH; power of two.

Ports:
- clk  in  1  single clock for all logic.
- rstn  in  1  reset, asynchronous and active-low.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_awaddr  in  C_M_AXI_ADDR_WIDTH  burst start byte address.
- s_axi_awlen  in  8  beats minus one.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_wdata  in  C_M_AXI_DATA_WIDTH  write data.
- s_axi_wstrb  in  C_M_AXI_DATA_WIDTH/8  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_bvalid  out  1  write response valid (OKAY implied).
- s_axi_bready  in  1  write response ready.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_araddr  in  C_M_AXI_ADDR_WIDTH  burst start byte address.
- s_axi_arlen  in  8  beats minus one.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axi_rdata  out  C_M_AXI_DATA_WIDTH  read data.
- s_axi_rlast  out  1  last read beat.
- wlast_err  out  1  sticky flag: wlast mismatch seen.

Behaviour:
Reset and addressing:
- Reset values, asynchronous: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, rdata=0, wlast_err=0; both FSMs in IDLE.
- Memory contents are not reset.
- Reset asserted mid-burst aborts the burst immediately: no bvalid and no further beats.
- Word index = addr[ADDR_LSB +: log2(MEM_DEPTH)], where ADDR_LSB = log2(C_M_AXI_DATA_WIDTH/8). Higher bits are ignored, so addressing wraps modulo the memory size.
- Unaligned low bits are ignored.
- Address advances one word per beat; the index wraps from MEM_DEPTH-1 to 0.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: awready=1. On awvalid, capture the word index and awlen into a beat counter, then go to W_DATA with awready=0.
- W_DATA: wready=1. Each wvalid&&wready beat writes the bytes selected by wstrb; bytes with strb=0 are unchanged.
- Beat count is authoritative. The burst ends on beat awlen+1 regardless of wlast.
- wlast_err is set if wlast=1 on a non-final beat, or wlast=0 on the final beat. Once set it is held until reset.
- After the final beat, go to W_RESP: wready=0 and bvalid=1 on the next cycle.
- W_RESP: hold bvalid until bready, then go to W_IDLE with awready=1 on the following cycle.
- awlen=0 gives a single beat.

Read FSM (R_IDLE, R_DATA):
- R_IDLE: arready=1. On arvalid, capture the index and arlen, then go to R_DATA with arready=0.
- R_DATA: the output register loads mem[idx] whenever (!rvalid || rready) and beats remain.
  - rvalid rises 1 cycle after the AR handshake.
  - Throughput is 1 beat/cycle while rready=1.
  - rdata, rvalid and rlast are held stable while rvalid && !rready.
- rlast=1 exactly on beat arlen+1.
- After the rlast handshake, return to R_IDLE with rvalid=0; arready=1 the next cycle.

Concurrency:
- Read and write channels are fully independent and may be active in the same cycle.
- A read and write to the same word in the same cycle: the read returns the old data (read-first).
- The AR and AW handshakes may occur in the same cycle.

Decomposition:
- Package axi_burst_mem_pkg:
  - w_state_t {W_IDLE, W_DATA, W_RESP} and r_state_t {R_IDLE, R_DATA}.
  - Function computing ADDR_LSB from the data width.
- One sub-module, axi_mem_bram_bwe: simple dual-port RAM with one write port using per-byte enables and one registered read port with read-enable and read-first behaviour, written so that BRAM is inferred.

Test Plan:
1. Write, awaddr=0x100, awlen=3, data 0xA0..0xA3, wstrb=0xF, bready=1 -> 4 beats accepted in consecutive cycles; bvalid 1 cycle after beat 4; wlast_err=0. Then read, araddr=0x100, arlen=3, rready=1 -> rdata 0xA0,0xA1,0xA2,0xA3 in consecutive cycles, rlast on the 4th beat only.
2. Byte strobes: word at 0x200 = 0x11223344, write 0xAABBCCDD with wstrb=0x5 -> read returns 0x11BB33DD.
3. Read backpressure: arlen=7, rready toggling 1,0,0,1,... -> data order unchanged; outputs stable while stalled; exactly 8 beats; single rlast.
4. Wrap: MEM_DEPTH=16, awaddr=0x3C, awlen=1, data 0x5,0x6 -> word 15=0x5, word 0=0x6. bready held 0 for 5 cycles -> bvalid held and awready=0 until the handshake.
5. Protocol error: awlen=2 with wlast on beat 2 -> 3 beats still accepted, bvalid after beat 3, wlast_err=1 and remaining 1 after a subsequent clean burst.
6. Concurrency and reset:
   - Simultaneous AW/AR to 0x40 (old 0x1, new 0x2) -> read returns 0x1.
   - rstn pulsed low mid-read-burst -> rvalid=0 immediately; arready=awready=1 after release; memory retains 0x2.

Source files
------------

// File: rtl/axi_burst_mem_pkg.sv
// Shared types and helpers for the AXI burst memory slave.
package axi_burst_mem_pkg;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Number of byte-offset bits below the word index for a given beat width.
    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi_mem_bram_bwe.sv
// Simple dual-port RAM: byte-enabled write port, registered read-first read port.
module axi_mem_bram_bwe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4096
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [DATA_WIDTH/8-1:0]    we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  logic                       re_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]      rdata_o
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (we_i[b]) begin
                mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Output register doubles as the AXI R data holding register (read-first on collision).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 INCR burst slave backed by an on-chip word memory with byte enables.
module axi_burst_mem_slave
    import axi_burst_mem_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH          = 4096
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,
    output logic                            wlast_err
);

    localparam int unsigned ADDR_LSB = addr_lsb(C_M_AXI_DATA_WIDTH);
    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
    localparam int unsigned STRB_W   = C_M_AXI_DATA_WIDTH / 8;

    // Write channel state
    w_state_t         w_state_q;
    logic [IDX_W-1:0] w_idx_q;
    logic [7:0]       w_rem_q;      // beats left after the current one
    logic             awready_q;
    logic             wready_q;
    logic             bvalid_q;
    logic             wlast_err_q;

    // Read channel state
    r_state_t         r_state_q;
    logic [IDX_W-1:0] r_idx_q;
    logic [8:0]       r_rem_q;      // beats not yet loaded into the output register
    logic             arready_q;
    logic             rvalid_q;
    logic             rlast_q;

    logic w_beat;
    logic w_final;
    logic r_load;

    // Only the index bits matter; the rest of each address is ignored on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    assign w_beat  = s_axi_wvalid && wready_q;
    assign w_final = (w_rem_q == 8'd0);
    assign r_load  = (r_state_q == R_DATA) && (!rvalid_q || s_axi_rready) && (r_rem_q != 9'd0);

    // Write FSM: accept AW, count beats (count wins over wlast), then hold B until taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q   <= W_IDLE;
            w_idx_q     <= '0;
            w_rem_q     <= '0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (s_axi_awvalid) begin
                        w_idx_q   <= s_axi_awaddr[ADDR_LSB +: IDX_W];
                        w_rem_q   <= s_axi_awlen;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_idx_q <= w_idx_q + IDX_W'(1);
                        w_rem_q <= w_rem_q - 8'd1;
                        if (s_axi_wlast != w_final) begin
                            wlast_err_q <= 1'b1;
                        end
                        if (w_final) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Read FSM: prefetch into the output register whenever it is empty or being drained.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_rem_q   <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        r_idx_q   <= s_axi_araddr[ADDR_LSB +: IDX_W];
                        r_rem_q   <= 9'(s_axi_arlen) + 9'd1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_load) begin
                        r_idx_q  <= r_idx_q + IDX_W'(1);
                        r_rem_q  <= r_rem_q - 9'd1;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (r_rem_q == 9'd1);
                    end else if (rvalid_q && s_axi_rready) begin
                        // Nothing left to load, so this handshake was the rlast beat.
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    axi_mem_bram_bwe #(
        .DATA_WIDTH (C_M_AXI_DATA_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .we_i    (s_axi_wstrb & {STRB_W{w_beat}}),
        .waddr_i (w_idx_q),
        .wdata_i (s_axi_wdata),
        .re_i    (r_load),
        .raddr_i (r_idx_q),
        .rdata_o (s_axi_rdata)
    );

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign wlast_err     = wlast_err_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Randomized bench for axi_burst_mem_slave with a transaction-level reference model.
module tb_axi_burst_mem_slave;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_bvalid, s_axi_bready;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic        s_axi_rlast;
    logic        wlast_err;

    always #5 clk = ~clk;

    axi_burst_mem_slave #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .MEM_DEPTH          (DEPTH)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rlast   (s_axi_rlast),
        .wlast_err     (wlast_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image plus observed-transaction bookkeeping.
    logic [31:0] mdl [DEPTH];
    logic [31:0] rq [$];
    int          wph;          // 0 no burst, 1 taking data, 2 response owed
    int          widx, wrem;
    bit          exp_err;
    bit          rbusy;
    int          rsince;
    bit          prev_stall;
    logic [31:0] prev_rdata;
    logic        prev_rlast;
    bit          run = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            if (run) begin
                check1("rst_awready", s_axi_awready, 1'b1);
                check1("rst_arready", s_axi_arready, 1'b1);
                check1("rst_wready", s_axi_wready, 1'b0);
                check1("rst_bvalid", s_axi_bvalid, 1'b0);
                check1("rst_rvalid", s_axi_rvalid, 1'b0);
                check1("rst_rlast", s_axi_rlast, 1'b0);
                check32("rst_rdata", s_axi_rdata, 32'h0);
                check1("rst_wlast_err", wlast_err, 1'b0);
            end
            wph = 0; rbusy = 1'b0; rsince = 0; rq.delete();
            exp_err = 1'b0; prev_stall = 1'b0;
        end else if (run) begin
            if (rbusy) rsince++;
            check1("wlast_err", wlast_err, exp_err);
            check1("awready", s_axi_awready, wph == 0);
            check1("wready", s_axi_wready, wph == 1);
            check1("bvalid", s_axi_bvalid, wph == 2);
            check1("arready", s_axi_arready, !rbusy);
            check1("rvalid", s_axi_rvalid, rbusy && rsince >= 2);
            if (prev_stall) begin
                check1("stall_rvalid", s_axi_rvalid, 1'b1);
                check32("stall_rdata", s_axi_rdata, prev_rdata);
                check1("stall_rlast", s_axi_rlast, prev_rlast);
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (rq.size() == 0) begin
                    check1("r_extra_beat", 1'b1, 1'b0);
                end else begin
                    check32("rdata", s_axi_rdata, rq[0]);
                    check1("rlast", s_axi_rlast, rq.size() == 1);
                    if (rq.size() == 1) rbusy = 1'b0;
                    void'(rq.pop_front());
                end
            end
            prev_stall = s_axi_rvalid && !s_axi_rready;
            prev_rdata = s_axi_rdata;
            prev_rlast = s_axi_rlast;
            if (s_axi_awvalid && s_axi_awready) begin
                wph  = 1;
                widx = int'((s_axi_awaddr / 4) % DEPTH);
                wrem = int'(s_axi_awlen);
            end
            if (s_axi_arvalid && s_axi_arready) begin
                int idx;
                idx = int'((s_axi_araddr / 4) % DEPTH);
                for (int k = 0; k <= int'(s_axi_arlen); k++) rq.push_back(mdl[(idx + k) % DEPTH]);
                rbusy  = 1'b1;
                rsince = 0;
            end
            if (s_axi_wvalid && s_axi_wready && wph == 1) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_axi_wstrb[b]) mdl[widx][8*b +: 8] = s_axi_wdata[8*b +: 8];
                end
                widx = (widx + 1) % DEPTH;
                if (wrem == 0) begin
                    if (!s_axi_wlast) exp_err = 1'b1;
                    wph = 2;
                end else begin
                    if (s_axi_wlast) exp_err = 1'b1;
                    wrem--;
                end
            end
            if (s_axi_bvalid && s_axi_bready && wph == 2) wph = 0;
        end
    end

    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];
    logic [31:0] rbuf [256];

    function automatic logic sig(input int which);
        case (which)
            0:       return s_axi_awready;
            1:       return s_axi_wready;
            2:       return s_axi_bvalid;
            default: return s_axi_arready;
        endcase
    endfunction

    // Waits (bounded) for a negedge where the signal is high, then steps past the next posedge.
    task automatic wait_hi(input int which, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!sig(which) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check1({name, "_timeout"}, 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input int bad,
                            input int max_gap, input int bdelay);
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awvalid = 1'b1;
        s_axi_bready  = (bdelay == 0);
        wait_hi(0, "aw");
        s_axi_awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wdat[b];
            s_axi_wstrb  = wstb[b];
            s_axi_wlast  = (b == len) ^ (b == bad);
            wait_hi(1, "w");
            s_axi_wvalid = 1'b0;
            s_axi_wlast  = 1'b0;
        end
        wait_hi(2, "b");
        if (bdelay > 0) begin
            repeat (bdelay - 1) begin
                @(posedge clk);
                #1;
            end
            s_axi_bready = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input int mode,
                           output int nb, output int nl);
        int  k;
        bit  done;
        nb = 0; nl = 0; done = 1'b0; k = 0;
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arvalid = 1'b1;
        wait_hi(3, "ar");
        s_axi_arvalid = 1'b0;
        while (!done && k < (len + 1) * 8 + 20) begin
            if (mode == 0)      s_axi_rready = 1'b1;
            else if (mode == 1) s_axi_rready = (k % 3 == 0);
            else                s_axi_rready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (s_axi_rvalid && s_axi_rready) begin
                if (nb < 256) rbuf[nb] = s_axi_rdata;
                nb++;
                if (s_axi_rlast) begin
                    nl++;
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            k++;
        end
        s_axi_rready = 1'b0;
        if (!done) check1("read_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int nb, nl, nb2, nl2;
        rstn = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0;
        s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
        s_axi_rready = 1'b0;
        #2 rstn = 1'b0;
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Fill the whole memory so every later read is defined.
        for (int i = 0; i < 16; i++) begin
            wdat[i] = $urandom;
            wstb[i] = 4'hF;
        end
        do_write(32'h0, 15, -1, 0, 0);

        // Basic 4-beat burst write then read-back.
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'hA0 + 32'(i);
            wstb[i] = 4'hF;
        end
        do_write(32'h100, 3, -1, 0, 0);
        check1("t1_wlast_err", wlast_err, 1'b0);
        do_read(32'h100, 3, 0, nb, nl);
        check32("t1_nbeats", 32'(nb), 32'd4);
        check32("t1_nlast", 32'(nl), 32'd1);
        for (int i = 0; i < 4; i++) check32("t1_rdata", rbuf[i], 32'hA0 + 32'(i));

        // Partial byte strobes.
        wdat[0] = 32'h11223344; wstb[0] = 4'hF;
        do_write(32'h200, 0, -1, 0, 0);
        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'h5;
        do_write(32'h200, 0, -1, 0, 0);
        do_read(32'h200, 0, 0, nb, nl);
        check32("t2_strb", rbuf[0], 32'h11BB33DD);

        // Read backpressure with rready 1,0,0 pattern.
        do_read(32'h300, 7, 1, nb, nl);
        check32("t3_nbeats", 32'(nb), 32'd8);
        check32("t3_nlast", 32'(nl), 32'd1);

        // Index wrap across the top of memory with a slow B channel.
        wdat[0] = 32'h5; wdat[1] = 32'h6; wstb[0] = 4'hF; wstb[1] = 4'hF;
        do_write(32'h3C, 1, -1, 0, 5);
        do_read(32'h3C, 1, 0, nb, nl);
        check32("t4_word15", rbuf[0], 32'h5);
        check32("t4_word0", rbuf[1], 32'h6);
        do_read(32'h0, 0, 0, nb, nl);
        check32("t4_word0_direct", rbuf[0], 32'h6);

        // Randomized traffic, one burst at a time.
        for (int op = 0; op < 40; op++) begin
            if ($urandom_range(0, 1) == 1) begin
                int len;
                len = int'($urandom_range(0, 20));
                for (int i = 0; i <= len; i++) begin
                    wdat[i] = $urandom;
                    wstb[i] = 4'($urandom_range(0, 15));
                end
                do_write($urandom, len, -1, 2, int'($urandom_range(0, 3)));
            end else begin
                do_read($urandom, int'($urandom_range(0, 20)), int'($urandom_range(0, 2)), nb, nl);
            end
        end

        // Early wlast: beat count still wins, error is sticky.
        for (int i = 0; i < 3; i++) begin
            wdat[i] = 32'hC0 + 32'(i);
            wstb[i] = 4'hF;
        end
        do_write(32'h80, 2, 1, 0, 0);
        check1("t5_err_set", wlast_err, 1'b1);
        do_write(32'h80, 1, -1, 1, 1);
        check1("t5_err_sticky", wlast_err, 1'b1);

        // Simultaneous AW/AR to the same word: read sees the old value.
        wdat[0] = 32'h1; wstb[0] = 4'hF;
        do_write(32'h40, 0, -1, 0, 0);
        wdat[0] = 32'h2;
        fork
            do_write(32'h40, 0, -1, 0, 0);
            do_read(32'h40, 0, 0, nb2, nl2);
        join
        check32("t6_read_first", rbuf[0], 32'h1);

        // Reset in the middle of a read burst.
        s_axi_araddr  = 32'h40;
        s_axi_arlen   = 8'd7;
        s_axi_arvalid = 1'b1;
        wait_hi(3, "ar");
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check1("t6_rst_rvalid", s_axi_rvalid, 1'b0);
        check1("t6_rst_arready", s_axi_arready, 1'b1);
        @(posedge clk);
        #1 rstn = 1'b1;
        s_axi_rready = 1'b0;
        @(negedge clk);
        check1("t6_post_arready", s_axi_arready, 1'b1);
        check1("t6_post_awready", s_axi_awready, 1'b1);
        @(posedge clk);
        #1;
        do_read(32'h40, 0, 0, nb, nl);
        check32("t6_mem_kept", rbuf[0], 32'h2);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
